pc_update_unit: RTL and testbench
=================================

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..7: number of fetch slots squashed after a redirect.
REQ-003 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port stall, input, 1 bit: hold PC and flush counter.
REQ-006 SHALL have port pc_src, input, 1 bit: registered branch-taken decision (branch & zero).
REQ-007 SHALL have port branch_base, input, 32 bits: PC+4 of the branch instruction.
REQ-008 SHALL have port branch_offset, input, 32 bits: sign-extended word offset.
REQ-009 SHALL have port jump, input, 1 bit: unconditional jump request.
REQ-010 SHALL have port jump_index, input, 26 bits: J-format target field.
REQ-011 SHALL have port pc_out, output, 32 bits: current fetch PC.
REQ-012 SHALL have port pc_plus4, output, 32 bits: combinational pc_out + 4.
REQ-013 SHALL have port flush, output, 1 bit: squash the instruction in fetch.
REQ-014 SHALL have port instr_valid, output, 1 bit: fetch slot holds a valid instruction, equal to !flush.
REQ-015 SHALL have port misalign_err, output, 1 bit: sticky misaligned-target flag (PC_MISALIGN_TRAP_EN only; tied 0 otherwise).

Function
REQ-016 SHALL compute the branch target as branch_base + (branch_offset << 2), modulo 2^32.
REQ-017 SHALL compute the jump target as {pc_plus4[31:28], jump_index, 2'b00}.
REQ-018 SHALL select next PC by priority: jump target, then branch target (pc_src=1), then pc_plus4.
REQ-019 SHALL treat "redirect" as jump | pc_src.
REQ-020 SHALL apply a redirect on the next rising edge even when stall=1 (redirect overrides stall).
REQ-021 SHALL hold pc_out when stall=1 and no redirect.
REQ-022 SHALL wrap pc_plus4 from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-023 SHALL implement FSM states IDLE and FLUSH: IDLE->FLUSH on redirect, loading counter with FLUSH_CYCLES-1.
REQ-024 SHALL, in FLUSH, decrement the counter on each non-stalled cycle and return to IDLE when the counter is 0 and no redirect is present.
REQ-025 SHALL, on a redirect while in FLUSH, reload the counter to FLUSH_CYCLES-1 and remain in FLUSH.
REQ-026 SHALL assert flush registered, exactly in the FLUSH state: one cycle after the redirect, for FLUSH_CYCLES non-stalled cycles.

Reset
REQ-027 SHALL, while reset=0, asynchronously force pc_out=RESET_PC, state=IDLE, counter=0, flush=0, misalign_err=0.
REQ-028 SHALL abandon any in-progress flush on reset, and SHALL perform the first update on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with PC_MISALIGN_TRAP_EN defined, check the selected redirect target: if target[1:0] != 0, the redirect is suppressed, pc_out holds, flush does not start, and misalign_err sets and stays set until reset.
REQ-030 SHALL, without PC_MISALIGN_TRAP_EN, load all targets unchecked and tie misalign_err to 0.

Structure
REQ-031 SHALL take the FSM state enum (IDLE, FLUSH), the PC width constant (32), and the instruction byte size (4) from the shared cpu_pkg package.
REQ-032 SHALL place the target computation (REQ-016 to REQ-018) in one combinational sub-module, next_pc_sel; the registers and FSM stay in pc_update_unit.

Verification
REQ-033 Reset then 3 free-running cycles -> pc_out sequence 0x0, 0x4, 0x8, 0xC; flush=0 throughout.
REQ-034 pc_out=0x10, pc_src=1, branch_base=0x14, branch_offset=-2 -> next pc_out=0x0C; flush=1 for exactly 2 cycles.
REQ-035 jump=1 and pc_src=1 in the same cycle, jump_index=0x40, pc_plus4=0x1000_0004 -> pc_out=0x1000_0100 (jump wins).
REQ-036 stall=1 with pc_src=1 (target 0x200) -> pc_out=0x200 on the next edge; a second redirect during FLUSH extends flush by 2 cycles from that point.
REQ-037 pc_out=0xFFFF_FFFC, no redirect -> pc_out=0x0; reset pulsed low mid-FLUSH -> flush=0 and pc_out=RESET_PC immediately.
REQ-038 PC_MISALIGN_TRAP_EN defined, branch target 0x102 -> pc_out unchanged, misalign_err=1 and held, flush=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC width, instruction size and the
// fetch-flush FSM state encoding.
package cpu_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_BYTES = 4;
    localparam int JUMP_IDX_W  = 26;
    // Wide enough for the largest reload value (FLUSH_CYCLES-1 <= 6).
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jump target, then branch target,
// then sequential fall-through.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [PC_WIDTH-1:0]   pc_plus4,
    input  logic                  pc_src,
    input  logic [PC_WIDTH-1:0]   branch_base,
    input  logic [PC_WIDTH-1:0]   branch_offset,
    input  logic                  jump,
    input  logic [JUMP_IDX_W-1:0] jump_index,
    output logic [PC_WIDTH-1:0]   next_pc,
    output logic                  redirect
);

    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;

    // Offset counts words; the add wraps modulo 2^32 by construction.
    assign branch_target = branch_base + (branch_offset << 2);
    assign jump_target   = {pc_plus4[PC_WIDTH-1:PC_WIDTH-4], jump_index, 2'b00};

    assign redirect = jump | pc_src;
    assign next_pc  = jump   ? jump_target   :
                      pc_src ? branch_target :
                               pc_plus4;

endmodule

// File: rtl/pc_update_unit.sv
// Program counter register with redirect handling and fetch-flush FSM.
// Optional feature: define PC_MISALIGN_TRAP_EN to suppress misaligned redirects.
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  pc_src,
    input  logic [PC_WIDTH-1:0]   branch_base,
    input  logic [PC_WIDTH-1:0]   branch_offset,
    input  logic                  jump,
    input  logic [JUMP_IDX_W-1:0] jump_index,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic [PC_WIDTH-1:0]   pc_plus4,
    output logic                  flush,
    output logic                  instr_valid,
    output logic                  misalign_err
);

    localparam logic [FLUSH_CNT_W-1:0] RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    logic [PC_WIDTH-1:0]    next_pc;
    logic                   redirect;
    logic                   take;
    flush_state_t           state, state_next;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_next;

    assign pc_plus4 = pc_out + PC_WIDTH'(INSTR_BYTES);

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .pc_src        (pc_src),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_hit;

    // A misaligned redirect is dropped entirely: no PC load, no flush.
    assign misalign_hit = redirect & (next_pc[1:0] != 2'b00);
    assign take         = redirect & ~misalign_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else if (misalign_hit) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign take         = redirect;
    assign misalign_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_out <= RESET_PC;
        end else if (take) begin
            pc_out <= next_pc;                 // redirect overrides stall
        end else if (!stall && !redirect) begin
            pc_out <= pc_plus4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_next = FLUSH;
                    cnt_next   = RELOAD;
                end
            end
            FLUSH: begin
                if (take) begin
                    cnt_next = RELOAD;
                end else if (!stall) begin
                    if (cnt == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign flush       = (state == FLUSH);
    assign instr_valid = ~flush;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed vector table, hand-written
// reset/misalign sequences and randomized traffic against a behavioural model.
module tb_pc_update_unit;

    localparam int FLUSH_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        instr_valid;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    pc_update_unit #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .instr_valid   (instr_valid),
        .misalign_err  (misalign_err)
    );

    typedef struct {
        logic        stall;
        logic        pc_src;
        logic [31:0] base;
        logic [31:0] off;
        logic        jump;
        logic [25:0] idx;
        logic [31:0] exp_pc;
        logic        exp_flush;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic ps, input logic [31:0] b,
                         input logic [31:0] o, input logic j, input logic [25:0] ix);
        stall         = s;
        pc_src        = ps;
        branch_base   = b;
        branch_offset = o;
        jump          = j;
        jump_index    = ix;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    endtask

    // Async reset pulse placed mid-cycle, away from the rising edge.
    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h1);
        check("rst_merr", {31'b0, misalign_err}, 32'h0);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // Rows applied in order straight after reset (pc_out = 0).
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0008, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_000C, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0010, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h14,        32'hFFFF_FFFE, 1'b0, 26'h0,  32'h0000_000C, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0010, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0014, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h1000_0000, 32'h0,         1'b0, 26'h0,  32'h1000_0000, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h2000,      32'h0,         1'b1, 26'h40, 32'h1000_0100, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h1000_0104, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h1000_0108, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h1000_0108, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h200,       32'h0,         1'b0, 26'h0,  32'h0000_0200, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0200, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0204, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h300,       32'h1,         1'b0, 26'h0,  32'h0000_0304, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0308, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_030C, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 32'h1,         1'b0, 26'h0,  32'hFFFF_FFFC, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0000, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,  32'h0000_0004, 1'b0};

        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        check("reset_pc", pc_out, 32'h0);
        check("reset_pc_plus4", pc_plus4, 32'h4);
        check("reset_flush", {31'b0, flush}, 32'h0);
        check("reset_valid", {31'b0, instr_valid}, 32'h1);
        check("reset_merr", {31'b0, misalign_err}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // ---- directed vector table ----
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].pc_src, vecs[i].base, vecs[i].off,
                  vecs[i].jump, vecs[i].idx);
            step();
            check($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
            check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
            check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, ~vecs[i].exp_flush});
        end

        // ---- reset pulsed mid-FLUSH ----
        drive(1'b0, 1'b1, 32'h500, 32'h0, 1'b0, 26'h0);
        step();
        check("midflush_pc", pc_out, 32'h500);
        check("midflush_flush", {31'b0, flush}, 32'h1);
        idle_inputs();
        pulse_reset();
        step();
        check("post_rst_pc", pc_out, 32'h4);
        check("post_rst_flush", {31'b0, flush}, 32'h0);

        // ---- misaligned branch target 0x102 ----
        drive(1'b0, 1'b1, 32'h102, 32'h0, 1'b0, 26'h0);
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", pc_out, 32'h4);
        check("mis_merr", {31'b0, misalign_err}, 32'h1);
        check("mis_flush", {31'b0, flush}, 32'h0);
        idle_inputs();
        step();
        check("mis_pc2", pc_out, 32'h8);
        check("mis_merr_held", {31'b0, misalign_err}, 32'h1);
        check("mis_flush2", {31'b0, flush}, 32'h0);
`else
        check("mis_pc", pc_out, 32'h102);
        check("mis_merr", {31'b0, misalign_err}, 32'h0);
        check("mis_flush", {31'b0, flush}, 32'h1);
        idle_inputs();
        step();
        check("mis_pc2", pc_out, 32'h106);
        check("mis_merr2", {31'b0, misalign_err}, 32'h0);
`endif

        // ---- randomized traffic against a behavioural model ----
        pulse_reset();
        begin
            logic [31:0] m_pc;
            int          m_left;
            logic [31:0] m_pp4;
            logic [31:0] idx32;
            logic        r_stall, r_src, r_jump;
            logic [31:0] r_base, r_off;
            logic [25:0] r_idx;
            int          bad = 0;

            m_pc   = 32'h0;
            m_left = 0;
            for (int c = 0; c < 600; c++) begin
                r_stall = ($urandom_range(0, 3) == 0);
                r_src   = ($urandom_range(0, 6) == 0);
                r_jump  = ($urandom_range(0, 9) == 0);
                r_base  = $urandom & 32'hFFFF_FFFC;
                r_off   = $urandom;
                r_idx   = 26'($urandom);
                drive(r_stall, r_src, r_base, r_off, r_jump, r_idx);

                m_pp4 = m_pc + 32'd4;
                if (pc_plus4 !== m_pp4) bad++;
                if (r_jump || r_src) begin
                    idx32 = 32'(r_idx);
                    m_pc  = r_jump ? ((m_pp4 & 32'hF000_0000) | (idx32 * 32'd4))
                                   : (r_base + r_off * 32'd4);
                    m_left = FLUSH_CYCLES;
                end else if (!r_stall) begin
                    m_pc = m_pp4;
                    if (m_left > 0) m_left--;
                end

                step();
                if (pc_out !== m_pc) begin
                    check($sformatf("rand%0d_pc", c), pc_out, m_pc);
                    bad++;
                end
                if (flush !== (m_left > 0) || instr_valid !== (m_left == 0)) begin
                    check($sformatf("rand%0d_flush", c), {31'b0, flush}, {31'b0, m_left > 0});
                    bad++;
                end
                if (misalign_err !== 1'b0) bad++;
            end
            check("rand_total_mismatches", bad, 32'h0);
            check("rand_final_pc", pc_out, m_pc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
